// File: rtl/serial_tx_arbiter_pkg.sv
// Shared constants and state encoding for the serial transmit path.
package serial_tx_arbiter_pkg;

  localparam int BYTE_W         = 8;
  localparam int CLOCK_HZ       = 48_000_000;
  localparam int BAUD           = 9600;
  localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD;

  typedef enum logic {IDLE, SEND} arb_state_t;

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester byte streams plus the serial_transmitter handshake, as seen by the arbiter.
interface serial_tx_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import serial_tx_arbiter_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [BYTE_W*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       grant_valid;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       aborted;
  logic [BYTE_W-1:0]          tx_data;
  logic                       tx_data_available;
  logic                       tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, grant_valid, grant_id, aborted, tx_data, tx_data_available
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, grant_valid, grant_id, aborted, tx_data, tx_data_available
  );

endinterface

// File: rtl/serial_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NUM_REQ.
module serial_tx_arbiter_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  logic [ID_W-1:0] cand [NUM_REQ];

  // cand[k] is the requester that sits k+1 places after ptr
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi] = ID_W'((int'(ptr) + gi + 1) % NUM_REQ);
  end

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        index = cand[k];
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one serial_transmitter among NUM_REQ byte streams.
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  serial_tx_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  PTR_INIT    = ID_W'(NUM_REQ - 1);

  arb_state_t        state_reg, state_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]  stall_reg, stall_next;

  logic              pick_found;
  logic [ID_W-1:0]   pick_index;
  logic [BYTE_W-1:0] data_lane [NUM_REQ];
  logic              owner_valid, owner_last;
  logic [BYTE_W-1:0] owner_data;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign data_lane[gi] = bus.req_data[gi*BYTE_W +: BYTE_W];
  end

  assign owner_valid = bus.req_valid[grant_reg];
  assign owner_last  = bus.req_last[grant_reg];
  assign owner_data  = data_lane[grant_reg];

  serial_tx_arbiter_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req   (bus.req_valid),
    .ptr   (ptr_reg),
    .found (pick_found),
    .index (pick_index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= PTR_INIT;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      stall_reg <= stall_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    grant_next            = grant_reg;
    ptr_next              = ptr_reg;
    stall_next            = stall_reg;
    bus.req_ready         = '0;
    bus.grant_valid       = 1'b0;
    bus.grant_id          = '0;
    bus.aborted           = 1'b0;
    bus.tx_data           = '0;
    bus.tx_data_available = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = SEND;
          grant_next = pick_index;
          stall_next = '0;
        end
      end
      SEND: begin
        bus.grant_valid          = 1'b1;
        bus.grant_id             = grant_reg;
        bus.tx_data              = owner_data;
        bus.tx_data_available    = owner_valid;
        bus.req_ready[grant_reg] = owner_valid & bus.tx_ready;
        // A busy UART with a byte waiting is not a stall
        if (owner_valid) begin
          stall_next = '0;
          if (bus.tx_ready && owner_last) begin
            state_next = IDLE;
            ptr_next   = grant_reg;
          end
        end else if (stall_reg == STALL_LIMIT) begin
          state_next  = IDLE;
          ptr_next    = grant_reg;
          bus.aborted = 1'b1;
        end else begin
          stall_next = stall_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench: requester byte queues in, scoreboard of expected UART transfers and aborts out.
module tb_serial_tx_arbiter;
  import serial_tx_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 16;

  typedef struct { logic [7:0] data; logic last; int gap; } req_byte_t;
  typedef struct { int id; logic [7:0] data; logic last; } xfer_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  serial_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  serial_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [N-1:0]   drv_valid = '0;
  logic [8*N-1:0] drv_data  = '0;
  logic [N-1:0]   drv_last  = '0;
  logic [N-1:0]   xfer_seen = '0;
  int             gap_cnt [N];
  logic           tx_hold = 1'b0;
  int             busy = 0;

  assign bus.req_valid = drv_valid;
  assign bus.req_data  = drv_data;
  assign bus.req_last  = drv_last;
  assign bus.tx_ready  = (busy == 0) && !tx_hold;

  req_byte_t req_q [0:N-1][$];
  xfer_t     exp_q[$];
  int        abort_q[$];
  int        checks = 0;
  int        errors = 0;
  logic      expect_idle = 1'b0;

  // Behavioural UART: busy for 20 cycles after each captured byte
  always @(posedge clock) begin
    if (bus.tx_data_available && bus.tx_ready) busy <= 20;
    else if (busy > 0) busy <= busy - 1;
  end

  // Requester drivers: pop on accepted byte, honour per-byte leading gap
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        req_q[i].delete();
        drv_valid[i] = 1'b0;
        xfer_seen[i] = 1'b0;
        gap_cnt[i]   = 0;
      end else begin
        if (xfer_seen[i]) begin
          void'(req_q[i].pop_front());
          xfer_seen[i] = 1'b0;
          drv_valid[i] = 1'b0;
          gap_cnt[i]   = (req_q[i].size() > 0) ? req_q[i][0].gap : 0;
        end
        if (!drv_valid[i] && req_q[i].size() > 0) begin
          if (gap_cnt[i] > 0) gap_cnt[i]--;
          else begin
            drv_valid[i]          = 1'b1;
            drv_data[i*8 +: 8]    = req_q[i][0].data;
            drv_last[i]           = req_q[i][0].last;
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (reset) begin
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        checks++;
        if (bus.grant_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_release grant_valid=%b expected 0", bus.grant_valid);
        end
        expect_idle = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        xfer_seen[i] = bus.req_valid[i] & bus.req_ready[i];
        if (bus.req_valid[i] && !(bus.grant_valid && int'(bus.grant_id) == i)) begin
          checks++;
          if (bus.req_ready[i] !== 1'b0) begin
            errors++;
            $display("FAIL nonowner_ready req=%0d ready=%b expected 0", i, bus.req_ready[i]);
          end
        end
      end
      if (bus.tx_data_available && bus.tx_ready) begin
        xfer_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer id=%0d data=%02h", bus.grant_id, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (int'(bus.grant_id) != e.id || bus.tx_data !== e.data ||
              bus.req_last[bus.grant_id] !== e.last || !bus.req_ready[bus.grant_id]) begin
            errors++;
            $display("FAIL xfer got id=%0d data=%02h last=%b expected id=%0d data=%02h last=%b",
                     bus.grant_id, bus.tx_data, bus.req_last[bus.grant_id], e.id, e.data, e.last);
          end else begin
            $display("xfer id=%0d data=%02h last=%b", bus.grant_id, bus.tx_data, e.last);
          end
          if (e.last) expect_idle = 1'b1;
        end
      end
      if (bus.aborted) begin
        checks++;
        if (abort_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_abort id=%0d", bus.grant_id);
        end else begin
          int a;
          a = abort_q.pop_front();
          if (int'(bus.grant_id) != a) begin
            errors++;
            $display("FAIL abort_id got %0d expected %0d", bus.grant_id, a);
          end else $display("abort id=%0d", a);
        end
        expect_idle = 1'b1;
      end
    end
  end

  task automatic push(input int i, input logic [7:0] d, input logic l, input int g);
    req_byte_t b;
    b.data = d; b.last = l; b.gap = g;
    req_q[i].push_back(b);
  endtask

  task automatic expect_xfer(input int i, input logic [7:0] d, input logic l);
    xfer_t e;
    e.id = i; e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() > 0) || (abort_q.size() > 0);
    for (int i = 0; i < N; i++) if (req_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL %s timeout exp_left=%0d abort_left=%0d expected 0", name, exp_q.size(), abort_q.size());
    end
    repeat (3) @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== '0 || bus.grant_valid !== 1'b0 || bus.grant_id !== '0 ||
        bus.aborted !== 1'b0 || bus.tx_data !== 8'h00 || bus.tx_data_available !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b gv=%b gid=%0d ab=%b txd=%02h txa=%b expected all 0",
               bus.req_ready, bus.grant_valid, bus.grant_id, bus.aborted, bus.tx_data,
               bus.tx_data_available);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // 1: two-byte message from req0
    push(0, 8'h48, 1'b0, 0); push(0, 8'h69, 1'b1, 0);
    expect_xfer(0, 8'h48, 1'b0); expect_xfer(0, 8'h69, 1'b1);
    wait_done("msg_req0", 500);

    // 2: simultaneous one-byte messages, twice; pointer must wrap
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push(0, 8'h10 + 8'(r), 1'b1, 0);
      push(1, 8'h20 + 8'(r), 1'b1, 0);
      push(2, 8'h30 + 8'(r), 1'b1, 0);
      expect_xfer(0, 8'h10 + 8'(r), 1'b1);
      expect_xfer(1, 8'h20 + 8'(r), 1'b1);
      expect_xfer(2, 8'h30 + 8'(r), 1'b1);
      wait_done("round_robin", 800);
    end

    // 3: req1 multi-byte message while req2 waits (pointer is at 2)
    push(1, 8'hA0, 1'b0, 0); push(1, 8'hA1, 1'b0, 0); push(1, 8'hA2, 1'b1, 0);
    push(2, 8'hB0, 1'b1, 0);
    expect_xfer(1, 8'hA0, 1'b0); expect_xfer(1, 8'hA1, 1'b0); expect_xfer(1, 8'hA2, 1'b1);
    expect_xfer(2, 8'hB0, 1'b1);
    wait_done("no_preempt", 800);

    // 4: req0 stalls mid-message, grant revoked, req1 takes over
    push(0, 8'h41, 1'b0, 0); push(0, 8'h42, 1'b1, 40);
    push(1, 8'h51, 1'b1, 0);
    expect_xfer(0, 8'h41, 1'b0);
    abort_q.push_back(0);
    expect_xfer(1, 8'h51, 1'b1);
    expect_xfer(0, 8'h42, 1'b1);
    wait_done("timeout_abort", 800);

    // 5: UART busy for a long time must not count as a stall
    tx_hold = 1'b1;
    push(0, 8'h55, 1'b1, 0);
    expect_xfer(0, 8'h55, 1'b1);
    repeat (100) @(posedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 1 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL busy_hold pending=%0d gv=%b gid=%0d expected 1 1 0",
               exp_q.size(), bus.grant_valid, bus.grant_id);
    end
    tx_hold = 1'b0;
    wait_done("busy_no_abort", 300);

    // 6: reset in the middle of req2's message, then fresh arbitration
    push(2, 8'hC0, 1'b0, 0); push(2, 8'hC1, 1'b1, 30);
    expect_xfer(2, 8'hC0, 1'b0);
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
        @(posedge clock);
        n++;
      end
    end
    repeat (2) @(posedge clock);
    do_reset();
    push(2, 8'hD2, 1'b1, 0);
    push(0, 8'hD0, 1'b1, 0);
    expect_xfer(0, 8'hD0, 1'b1);
    expect_xfer(2, 8'hD2, 1'b1);
    wait_done("after_reset", 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
